multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 155 +++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with a sticky trap state for unsupported opcodes and a retired-instruction
// counter. Control outputs are decoded from the current state and the opcode
// latched in DECODE; only the FETCH/MEM handshake looks at mem_ready.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_b,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_TRAP   = 3'b110,
    S_BAD    = 3'b111
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic       illegal;
  } ctrl_t;

  state_t      st_q, st_d;
  logic [6:0]  op_q;
  logic [15:0] cnt_q;
  logic        retire;
  ctrl_t       ctl;

  // instruction class of the latched opcode
  logic is_r, is_i, is_ld, is_st, is_br, op_ok;
  assign is_r  = (op_q == OP_R);
  assign is_i  = (op_q == OP_I);
  assign is_ld = (op_q == OP_LD);
  assign is_st = (op_q == OP_ST);
  assign is_br = (op_q == OP_BR);
  // legality is judged on the live opcode, since it is only sampled in DECODE
  assign op_ok = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD) ||
                 (opcode == OP_ST) || (opcode == OP_BR);

  // state, latched opcode and retire counter; reset drops any pending request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q  <= S_IDLE;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + 16'd1;
    end
  end

  // next state and control decode; everything defaults to 0
  always_comb begin
    st_d   = st_q;
    retire = 1'b0;
    ctl    = '0;
    case (st_q)
      S_IDLE: if (run) st_d = S_FETCH;
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          st_d         = S_DECODE;
        end
      end
      S_DECODE: st_d = op_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_r || is_i) begin
          ctl.alu_op    = 2'b10;
          ctl.alu_src_b = is_i;
          st_d          = S_WB;
        end else if (is_ld || is_st) begin
          ctl.alu_src_b = 1'b1;
          st_d          = S_MEM;
        end else if (is_br) begin
          ctl.alu_op        = 2'b01;
          ctl.pc_write_cond = 1'b1;
          retire            = 1'b1;
        end else begin
          // not reachable through DECODE; park rather than guess
          st_d = S_TRAP;
        end
      end
      S_MEM: begin
        ctl.alu_src_b = 1'b1;
        ctl.mem_read  = is_ld;
        ctl.mem_write = is_st;
        if (mem_ready) begin
          if (is_ld) st_d = S_WB;
          else       retire = 1'b1;
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = is_ld;
        retire         = 1'b1;
      end
      // absorbing until reset, so illegal is sticky by construction
      S_TRAP: begin
        ctl.illegal = 1'b1;
        st_d        = S_TRAP;
      end
      default: st_d = S_IDLE;
    endcase
    if (retire) st_d = run ? S_FETCH : S_IDLE;
  end

  assign alu_op        = ctl.alu_op;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign reg_write     = ctl.reg_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign alu_src_b     = ctl.alu_src_b;
  assign illegal       = ctl.illegal;
  assign state         = st_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded by a reference
// model into its expected per-cycle trace (state, control word, mem_ready to
// drive) from the instruction class and wait-state counts, then replayed.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset_n, run, mem_ready;
  logic [6:0]  opcode;
  logic [1:0]  alu_op;
  logic        mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic        reg_write, mem_to_reg, alu_src_b, illegal;
  logic [2:0]  state;
  logic [15:0] instr_count;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .mem_ready(mem_ready), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] m_cnt;

  typedef struct packed { logic [2:0] st; logic rdy; logic [10:0] o; } ent_t;
  ent_t tq[$];

  logic [10:0] obs;
  assign obs = {alu_op, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
                reg_write, mem_to_reg, alu_src_b, illegal};

  // control word in the same order as obs
  function automatic logic [10:0] ov(logic [1:0] a, logic mr, logic mw, logic irw,
      logic pcw, logic pcc, logic rw, logic m2r, logic sb, logic ill);
    return {a, mr, mw, irw, pcw, pcc, rw, m2r, sb, ill};
  endfunction

  function automatic ent_t mk(logic [2:0] st, logic rdy, logic [10:0] o);
    return {st, rdy, o};
  endfunction

  // class: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 illegal
  function automatic logic [6:0] opc(int k);
    case (k)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build(int k, int fw, int mw);
    logic [10:0] mo;
    tq.delete();
    repeat (fw) tq.push_back(mk(3'd1, 1'b0, ov(2'b00,1,0,0,0,0,0,0,0,0)));
    tq.push_back(mk(3'd1, 1'b1, ov(2'b00,1,0,1,1,0,0,0,0,0)));
    tq.push_back(mk(3'd2, rb(), 11'd0));
    if (k == 5) begin
      repeat (6) tq.push_back(mk(3'd6, rb(), ov(2'b00,0,0,0,0,0,0,0,0,1)));
      return;
    end
    case (k)
      0: tq.push_back(mk(3'd3, rb(), ov(2'b10,0,0,0,0,0,0,0,0,0)));
      1: tq.push_back(mk(3'd3, rb(), ov(2'b10,0,0,0,0,0,0,0,1,0)));
      2, 3: tq.push_back(mk(3'd3, rb(), ov(2'b00,0,0,0,0,0,0,0,1,0)));
      default: tq.push_back(mk(3'd3, rb(), ov(2'b01,0,0,0,0,1,0,0,0,0)));
    endcase
    if (k == 2 || k == 3) begin
      mo = ov(2'b00, k == 2, k == 3, 0, 0, 0, 0, 0, 1, 0);
      repeat (mw) tq.push_back(mk(3'd4, 1'b0, mo));
      tq.push_back(mk(3'd4, 1'b1, mo));
    end
    if (k <= 2) tq.push_back(mk(3'd5, rb(), ov(2'b00,0,0,0,0,0,1,k == 2,0,0)));
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(ent_t e, logic [6:0] op_in, logic run_in);
    @(negedge clk);
    mem_ready = e.rdy; opcode = op_in; run = run_in;
    #1;
    chk("state", 32'(state), 32'(e.st));
    chk("ctrl", 32'(obs), 32'(e.o));
    chk("count", 32'(instr_count), 32'(m_cnt));
    chk("mem_excl", 32'(mem_read & mem_write), 32'd0);
  endtask

  task automatic idle_step(logic run_in);
    step(mk(3'd0, rb(), 11'd0), 7'($urandom), run_in);
  endtask

  // drop: run falls from EXEC onward; stop>=0 abandons the trace at that entry
  task automatic run_instr(int k, int fw, int mw, bit drop, int stop);
    logic [6:0] op;
    logic r;
    build(k, fw, mw);
    foreach (tq[i]) begin
      if (stop >= 0 && i == stop) return;
      op = (tq[i].st == 3'd2) ? opc(k) : 7'($urandom);
      r  = (drop && i >= fw + 2) ? 1'b0 : 1'b1;
      if (tq[i].st == 3'd6) r = rb();
      step(tq[i], op, r);
    end
    if (k != 5) m_cnt++;
  endtask

  initial begin
    m_cnt = 16'd0;
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    // outputs pinned while reset is held, whatever the inputs do
    repeat (2) begin
      @(negedge clk); run = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011; #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctrl", 32'(obs), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
    end
    @(negedge clk); reset_n = 1'b1; run = 1'b0;
    idle_step(1'b0);
    idle_step(1'b1);

    run_instr(0, 0, 0, 0, -1);   // R-type, zero waits
    run_instr(2, 2, 1, 0, -1);   // load, 2 fetch waits + 1 mem wait
    run_instr(4, 0, 0, 0, -1);   // branch
    run_instr(1, 0, 0, 0, -1);   // I-type
    run_instr(3, 0, 0, 0, -1);   // store
    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 0, -1);

    // run dropped mid-instruction: completes, then parks
    run_instr(2, 1, 1, 1, -1);
    idle_step(1'b0);
    idle_step(1'b0);

    // counter wrap: preset to 0xFFFF while parked, then retire one more
    dut.cnt_q <= 16'hFFFF;
    m_cnt = 16'hFFFF;
    idle_step(1'b1);
    run_instr(0, 0, 0, 1, -1);
    idle_step(1'b0);
    idle_step(1'b1);

    // store stalled in MEM, then reset kills the request
    run_instr(3, 0, 5, 0, 6);
    @(negedge clk); reset_n = 1'b0; mem_ready = 1'b0; run = 1'b1;
    m_cnt = 16'd0;
    @(negedge clk); #1;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_memw", 32'(mem_write), 32'd0);
    chk("mrst_count", 32'(instr_count), 32'd0);
    @(negedge clk); reset_n = 1'b1; run = 1'b1; #1;
    chk("mrst_idle", 32'(state), 32'd0);

    run_instr(4, 0, 0, 0, -1);
    run_instr(0, 1, 0, 0, -1);

    // illegal opcode: stuck in TRAP, run ignored, count frozen
    run_instr(5, 1, 0, 0, -1);
    @(negedge clk); reset_n = 1'b0; run = 1'b0;
    m_cnt = 16'd0;
    @(negedge clk); #1;
    chk("trst_state", 32'(state), 32'd0);
    chk("trst_illegal", 32'(illegal), 32'd0);
    chk("trst_count", 32'(instr_count), 32'd0);
    reset_n = 1'b1;
    idle_step(1'b1);
    run_instr(0, 0, 0, 0, -1);
    run_instr(2, 0, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
